// File: rtl/dmem_pkg.sv
// Shared types and widths for the data-memory responder.
package dmem_pkg;
  localparam int WORD_W = 32;
  localparam int BE_W   = 4;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;
endpackage

// File: rtl/dmem_if.sv
// Core <-> data-memory request/ack bus.
interface dmem_if;
  import dmem_pkg::*;
  logic              req;
  logic              we;
  logic [31:0]       addr;
  logic [WORD_W-1:0] wdata;
  logic [BE_W-1:0]   be;
  logic              ready;
  logic              ack;
  logic [WORD_W-1:0] rdata;
  logic              err;

  modport master (output req, we, addr, wdata, be, input ready, ack, rdata, err);
  modport slave  (input req, we, addr, wdata, be, output ready, ack, rdata, err);
endinterface

// File: rtl/dmem_ram.sv
// Word-wide data RAM: byte-enabled synchronous write, registered read.
module dmem_ram
  import dmem_pkg::*;
#(
  parameter int    ADDR_W   = 10,
  parameter string MEM_INIT = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] idx_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [BE_W-1:0]   be_i,
  output logic [WORD_W-1:0] rdata_o
);
  logic [WORD_W-1:0] mem [2**ADDR_W];
  logic [WORD_W-1:0] rd_q;

  // Byte-lane write; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (en_i && we_i) begin
      for (int b = 0; b < BE_W; b++)
        if (be_i[b]) mem[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
  end

  // Registered read port, only updated by loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            rd_q <= '0;
    else if (en_i && !we_i) rd_q <= mem[idx_i];
  end

  assign rdata_o = rd_q;
endmodule

// File: rtl/dmem_responder.sv
// Wait-stated data-memory responder: IDLE -> BUSY (WAIT_CYCLES) -> RESP.
// The RAM is accessed on the edge entering RESP, so a reset during BUSY
// discards the pending store. Optional DMEM_ALIGN_CHK_EN flags misaligned
// accesses with err at ack and suppresses the RAM access.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int    ADDR_W      = 10,
  parameter int    WAIT_CYCLES = 2,
  parameter string MEM_INIT    = ""
) (
  input  logic   clk,
  input  logic   reset_n,
  dmem_if.slave  bus
);
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q;
  logic [31:0]       addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;
  logic              accept, enter_resp;

  // With WAIT_CYCLES=0 the access happens on the accepting edge, so the
  // RAM sees the live bus in IDLE and the latched copy otherwise.
  logic              acc_we;
  logic [31:0]       acc_addr;
  logic [WORD_W-1:0] acc_wdata;
  logic [BE_W-1:0]   acc_be;
  logic              acc_mis, resp_mis;
  logic [WORD_W-1:0] ram_rd;

  assign acc_we    = (state_q == IDLE) ? bus.we    : we_q;
  assign acc_addr  = (state_q == IDLE) ? bus.addr  : addr_q;
  assign acc_wdata = (state_q == IDLE) ? bus.wdata : wdata_q;
  assign acc_be    = (state_q == IDLE) ? bus.be    : be_q;

`ifdef DMEM_ALIGN_CHK_EN
  assign acc_mis  = (acc_addr[1:0] != 2'b00);
  assign resp_mis = (addr_q[1:0] != 2'b00);
`else
  assign acc_mis  = 1'b0;
  assign resp_mis = 1'b0;
`endif

  // Byte-offset and out-of-range address bits are intentionally dropped.
  wire unused_ok = ^{acc_addr[31:ADDR_W+2], acc_addr[1:0]};

  // Next-state and wait counter.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: if (bus.req) begin
        accept = 1'b1;
        cnt_d  = CNT_W'(WAIT_CYCLES);
        if (WAIT_CYCLES > 0) state_d = BUSY;
        else begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP:    begin state_d = IDLE; cnt_d = '0; end
      default: state_d = IDLE;
    endcase
  end

  // State, counter and latched request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= bus.we;
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
        be_q    <= bus.be;
      end
    end
  end

  dmem_ram #(.ADDR_W(ADDR_W), .MEM_INIT(MEM_INIT)) u_ram (
    .clk     (clk),
    .rst_n   (reset_n),
    .en_i    (enter_resp && !acc_mis),
    .we_i    (acc_we),
    .idx_i   (acc_addr[ADDR_W+1:2]),
    .wdata_i (acc_wdata),
    .be_i    (acc_be),
    .rdata_o (ram_rd)
  );

  assign bus.ready = (state_q == IDLE);
  assign bus.ack   = (state_q == RESP);
  assign bus.err   = (state_q == RESP) && resp_mis;
  assign bus.rdata = ((state_q == RESP) && !we_q && !resp_mis) ? ram_rd : '0;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed scoreboard bench for dmem_responder (ADDR_W=10, WAIT_CYCLES=2).
// Build with +define+DMEM_ALIGN_CHK_EN to exercise the alignment-check variant.
module tb_dmem_responder;
  localparam int LAT = 3;

  typedef struct {
    logic        is_load;
    logic [31:0] rdata;
    logic        err;
    int          acc;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   n_acks = 0;
  int   n_xact = 0;
  exp_t sb[$];

  dmem_if bus();

  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(2), .MEM_INIT("")) dut (
    .clk     (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pop one expectation per ack and compare.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.ack === 1'b1) begin
      exp_t e;
      n_acks++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_ack: ack at cycle %0d with nothing outstanding", cyc);
      end else begin
        e = sb.pop_front();
        chk({"lat_", e.name}, 32'(cyc - e.acc), 32'(LAT));
        chk({"err_", e.name}, {31'b0, bus.err}, {31'b0, e.err});
        if (e.is_load) chk({"rdata_", e.name}, bus.rdata, e.rdata);
      end
    end
  end

  // Issue one transaction, push its expectation, wait for its ack.
  task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] b, input logic [31:0] exp_rd, input logic exp_err,
                      input bit drop, input string nm, output int acc_cyc, output int ack_cyc);
    exp_t e;
    int n;
    @(negedge clk);
    bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d; bus.be = b;
    n = 0;
    while (bus.ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    acc_cyc = cyc;
    ack_cyc = cyc;
    if (bus.ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL accept_timeout_%s: ready stayed %b, required 1", nm, bus.ready);
      bus.req = 1'b0;
      return;
    end
    e.is_load = !w; e.rdata = exp_rd; e.err = exp_err; e.acc = cyc; e.name = nm;
    sb.push_back(e);
    n_xact++;
    @(negedge clk);
    chk({"busy_ready_", nm}, {31'b0, bus.ready}, 32'd0);
    if (drop) begin
      bus.req = 1'b0; bus.we = 1'b1; bus.addr = 32'h200; bus.wdata = 32'h0; bus.be = 4'hF;
    end
    n = 0;
    while (bus.ack !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (bus.ack !== 1'b1) begin
      checks++; errors++;
      $display("FAIL ack_timeout_%s: ack stayed %b, required 1", nm, bus.ack);
    end
    ack_cyc = cyc;
    bus.req = 1'b0;
  endtask

  initial begin
    int a0, k0, a1, k1;
    logic [31:0] exp_w100;
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0; bus.be = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'b0, bus.ready}, 32'd1);
    chk("rst_ack",   {31'b0, bus.ack},   32'd0);
    chk("rst_rdata", bus.rdata,          32'd0);
    chk("rst_err",   {31'b0, bus.err},   32'd0);
    rst_n = 1'b1;

    // Reset in the middle of a store discards it.
    xact(1'b1, 32'h40, 32'h01234567, 4'hF, 32'h0, 1'b0, 1'b0, "pre40", a0, k0);
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 32'h40; bus.wdata = 32'hDEADBEEF; bus.be = 4'hF;
    @(negedge clk);
    bus.req = 1'b0;
    chk("abort_busy", {31'b0, bus.ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ready", {31'b0, bus.ready}, 32'd1);
    chk("async_rst_ack",   {31'b0, bus.ack},   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    xact(1'b0, 32'h40, 32'h0, 4'h0, 32'h01234567, 1'b0, 1'b0, "ld40", a0, k0);

    // Store then back-to-back load.
    xact(1'b1, 32'h100, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, 1'b0, "st100", a0, k0);
    xact(1'b0, 32'h100, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, 1'b0, "ld100", a1, k1);
    chk("b2b_accept", 32'(a1), 32'(k0 + 1));

    // Byte enables and a be=0 store.
    xact(1'b1, 32'h200, 32'h11223344, 4'hF, 32'h0, 1'b0, 1'b0, "st200", a0, k0);
    xact(1'b1, 32'h200, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0, 1'b0, "st200be", a0, k0);
    xact(1'b0, 32'h200, 32'h0, 4'h0, 32'h11BB33DD, 1'b0, 1'b0, "ld200be", a0, k0);
    xact(1'b1, 32'h200, 32'hFFFFFFFF, 4'b0000, 32'h0, 1'b0, 1'b0, "st200be0", a0, k0);
    xact(1'b0, 32'h200, 32'h0, 4'h0, 32'h11BB33DD, 1'b0, 1'b0, "ld200be0", a0, k0);

    // Index wraps modulo 2**ADDR_W.
    xact(1'b1, 32'h1000, 32'h5A5A5A5A, 4'hF, 32'h0, 1'b0, 1'b0, "st1000", a0, k0);
    xact(1'b0, 32'h0, 32'h0, 4'h0, 32'h5A5A5A5A, 1'b0, 1'b0, "ld0wrap", a0, k0);

    // req dropped (and inputs scrambled) during BUSY of a load.
    xact(1'b0, 32'h100, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, 1'b1, "lddrop", a0, k0);
    repeat (8) @(negedge clk);
    chk("drop_acks", 32'(n_acks), 32'(n_xact));

    // Misaligned access.
`ifdef DMEM_ALIGN_CHK_EN
    xact(1'b1, 32'h102, 32'h12345678, 4'hF, 32'h0, 1'b1, 1'b0, "st102", a0, k0);
    exp_w100 = 32'hCAFEF00D;
    xact(1'b0, 32'h102, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, "ld102", a0, k0);
`else
    xact(1'b1, 32'h102, 32'h12345678, 4'hF, 32'h0, 1'b0, 1'b0, "st102", a0, k0);
    exp_w100 = 32'h12345678;
    xact(1'b0, 32'h102, 32'h0, 4'h0, 32'h12345678, 1'b0, 1'b0, "ld102", a0, k0);
`endif
    xact(1'b0, 32'h100, 32'h0, 4'h0, exp_w100, 1'b0, 1'b0, "ld100post", a0, k0);

    repeat (6) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("ack_total", 32'(n_acks), 32'(n_xact));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1);
  end
endmodule
